step_tick_ctrl: RTL

STEP_TICK_CTRL -- requirements
Module: step_tick_ctrl

---
 rtl/step_tick_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/step_tick_ctrl.sv
// Tick generator for the sequence datapath: free-running ticks at a selectable
// period while run is high, or single ticks on rising edges of step while halted.
module step_tick_ctrl #(
    parameter logic [25:0] RATE0 = 26'd25000000,
    parameter logic [25:0] RATE1 = 26'd12500000,
    parameter logic [25:0] RATE2 = 26'd5000000,
    parameter logic [25:0] RATE3 = 26'd1000000
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic [1:0] rate_sel,
    output logic       tick,
    output logic [1:0] state,
    output logic [7:0] tick_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [25:0] cnt_r;
    logic [25:0] cnt_next_s;
    logic [25:0] period_s;
    logic        step_prev_r;
    logic [1:0]  rate_sel_r;
    logic        tick_r;
    logic        tick_next_s;
    logic [7:0]  tick_count_r;
    logic        step_edge_s;
    logic        rate_chg_s;

    assign step_edge_s = step & ~step_prev_r;
    assign rate_chg_s  = (rate_sel != rate_sel_r);

    // Period selected by the live rate_sel; a change reloads the counter anyway.
    always_comb begin
        period_s = RATE0;
        case (rate_sel)
            2'd0:    period_s = RATE0;
            2'd1:    period_s = RATE1;
            2'd2:    period_s = RATE2;
            2'd3:    period_s = RATE3;
            default: period_s = RATE0;
        endcase
    end

    // Next-state, counter and tick decode; tick is computed one cycle early
    // so the registered pulse lines up with the STEP state and counter wrap.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        tick_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_next_s = 26'd0;
                if (run) begin
                    state_next_s = ST_RUN;
                end else if (step_edge_s) begin
                    state_next_s = ST_STEP;
                    tick_next_s  = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 26'd0;
                end else if (rate_chg_s) begin
                    cnt_next_s = 26'd0;
                end else if (cnt_r == (period_s - 26'd1)) begin
                    cnt_next_s  = 26'd0;
                    tick_next_s = 1'b1;
                end else begin
                    cnt_next_s = cnt_r + 26'd1;
                end
            end
            ST_STEP: begin
                cnt_next_s = 26'd0;
                if (run) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 26'd0;
            end
        endcase
    end

    // State, counter, edge detector, rate copy and registered outputs.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 26'd0;
            tick_r       <= 1'b0;
            tick_count_r <= 8'd0;
            step_prev_r  <= 1'b1;
            rate_sel_r   <= rate_sel;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            tick_r       <= tick_next_s;
            tick_count_r <= tick_count_r + {7'd0, tick_next_s};
            step_prev_r  <= step;
            rate_sel_r   <= rate_sel;
        end
    end

    assign tick       = tick_r;
    assign state      = state_r;
    assign tick_count = tick_count_r;

endmodule
